multiword_add_ctrl: RTL and testbench

//   Sequencer that performs a WORDS*N-bit add on one shared N-bit catalog adder (adder #(.n(N))).

---
 rtl/multiword_add_ctrl.sv | 109 ++++++++++
 tb/tb_multiword_add_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/multiword_add_ctrl.sv
// Wide (N*WORDS-bit) adder built from one N-bit adder, fed one slice per cycle, LSB slice first.
// The carry between slices is held in a flop. A start/busy/done handshake fronts the sequencer.

module adder #(
    parameter int n = 8
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         cin,
    output logic [n-1:0] sum,
    output logic         cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{n{1'b0}}, cin};
endmodule

module multiword_add_ctrl #(
    parameter int N     = 8,
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [N*WORDS-1:0]   a,
    input  logic [N*WORDS-1:0]   b,
    input  logic                 cin,
    output logic                 busy,
    output logic                 done,
    output logic [N*WORDS-1:0]   sum,
    output logic                 cout
);
    localparam int W  = N * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Handshake: start is taken only in IDLE or DONE; busy marks RUN;
    // done is a single-cycle pulse after which sum/cout stay valid until overwritten.
    logic [1:0]    state;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic          cin_reg;
    logic          carry;
    logic [IW-1:0] idx;
    logic [31:0]   base;

    logic [N-1:0]  slice_a;
    logic [N-1:0]  slice_b;
    logic [N-1:0]  slice_sum;
    logic          slice_cin;
    logic          slice_cout;

    assign base      = 32'(idx) * 32'(N);
    assign slice_a   = a_reg[base +: N];
    assign slice_b   = b_reg[base +: N];
    assign slice_cin = (idx == '0) ? cin_reg : carry;

    adder #(.n(N)) u_adder (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (slice_cin),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            cin_reg <= 1'b0;
            carry   <= 1'b0;
            idx     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_reg   <= a;
                        b_reg   <= b;
                        cin_reg <= cin;
                        idx     <= '0;
                        state   <= S_RUN;
                    end else begin
                        state   <= S_IDLE;
                    end
                end
                S_RUN: begin
                    sum[base +: N] <= slice_sum;
                    carry          <= slice_cout;
                    if (idx == LAST) begin
                        cout  <= slice_cout;
                        idx   <= '0;
                        state <= S_DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multiword_add_ctrl.sv
// Bench for multiword_add_ctrl (N=8, WORDS=4): directed scenarios plus random ops
// checked against a plain a+b+cin reference.

module tb_multiword_add_ctrl;
    localparam int N     = 8;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int n_checks;
    int n_pass;

    logic [W:0] exp_q[$];

    multiword_add_ctrl #(.N(N), .WORDS(WORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W:0] golden(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + (W+1)'(c);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after an edge with the DUT in IDLE or DONE. Returns at the done cycle.
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                         input bit keep_start, output int cycles, output int busy_cycles);
        a = x; b = y; cin = c; start = 1'b1;
        tick();
        if (!keep_start) start = 1'b0;
        cycles = 0;
        busy_cycles = 0;
        while (!done && cycles < 20) begin
            if (busy) busy_cycles++;
            tick();
            cycles++;
        end
        if (!done) cycles = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({busy, done, cout, sum} !== {3'b000, {W{1'b0}}})
            $display("FAIL reset: busy=%b done=%b cout=%b sum=%h expected all zero", busy, done, cout, sum);
        else n_pass++;
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_idle: busy=%b done=%b expected 0 0", busy, done);
        else n_pass++;
    endtask

    task automatic test_carry_ripple();
        int cyc, bcyc;
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, cyc, bcyc);
        n_checks++;
        if ({cout, sum} !== {1'b1, 32'h0000_0000})
            $display("FAIL ripple_result: got cout=%b sum=%h expected cout=1 sum=00000000", cout, sum);
        else n_pass++;
        n_checks++;
        if (cyc !== 4) $display("FAIL ripple_latency: got %0d cycles expected 4", cyc);
        else n_pass++;
        n_checks++;
        if (bcyc !== 4) $display("FAIL ripple_busy: busy for %0d cycles expected 4", bcyc);
        else n_pass++;
        tick();
        n_checks++;
        if (done !== 1'b0) $display("FAIL ripple_done_pulse: done=%b one cycle later expected 0", done);
        else n_pass++;
    endtask

    task automatic test_cin_only();
        int cyc, bcyc;
        do_op(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, cyc, bcyc);
        n_checks++;
        if ({cout, sum} !== {1'b0, 32'h0000_0001})
            $display("FAIL cin_only: got cout=%b sum=%h expected cout=0 sum=00000001", cout, sum);
        else n_pass++;
        do_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, cyc, bcyc);
        n_checks++;
        if ({cout, sum} !== {1'b0, 32'h2345_6789})
            $display("FAIL plain_add: got cout=%b sum=%h expected cout=0 sum=23456789", cout, sum);
        else n_pass++;
        repeat (3) tick();
        n_checks++;
        if ({cout, sum} !== {1'b0, 32'h2345_6789} || busy !== 1'b0)
            $display("FAIL idle_hold: got cout=%b sum=%h busy=%b expected 0 23456789 0", cout, sum, busy);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int cyc1, cyc2, bcyc;
        do_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, cyc1, bcyc);
        n_checks++;
        if ({cout, sum} !== {1'b1, 32'h0000_0000})
            $display("FAIL b2b_first: got cout=%b sum=%h expected cout=1 sum=00000000", cout, sum);
        else n_pass++;
        do_op(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b1, cyc2, bcyc);
        start = 1'b0;
        n_checks++;
        if ({cout, sum} !== {1'b0, 32'h0001_0000})
            $display("FAIL b2b_second: got cout=%b sum=%h expected cout=0 sum=00010000", cout, sum);
        else n_pass++;
        n_checks++;
        if (cyc2 + 1 !== 5) $display("FAIL b2b_spacing: done pulses %0d cycles apart expected 5", cyc2 + 1);
        else n_pass++;
        tick();
        n_checks++;
        if (busy !== 1'b0) $display("FAIL b2b_release: busy=%b after start dropped expected 0", busy);
        else n_pass++;
    endtask

    task automatic test_start_during_run();
        logic [W-1:0] x, y;
        logic [W:0]   e;
        int           cyc;
        x = $urandom(); y = $urandom();
        e = golden(x, y, 1'b1);
        a = x; b = y; cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        a = ~x; b = $urandom(); cin = 1'b0; start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 20) begin
            tick();
            cyc++;
        end
        n_checks++;
        if ({cout, sum} !== e)
            $display("FAIL run_start_ignored: got %h expected %h", {cout, sum}, e);
        else n_pass++;
        tick();
        n_checks++;
        if (busy !== 1'b0) $display("FAIL run_start_not_queued: busy=%b expected 0", busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        int cyc, bcyc;
        a = 32'hA5A5_A5A5; b = 32'h0F0F_0F0F; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, cout, sum} !== {3'b000, {W{1'b0}}})
            $display("FAIL reset_mid_run: busy=%b done=%b cout=%b sum=%h expected all zero", busy, done, cout, sum);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_abort: busy=%b after release expected 0", busy);
        else n_pass++;
        do_op(32'hDEAD_BEEF, 32'h2152_4111, 1'b1, 1'b0, cyc, bcyc);
        n_checks++;
        if ({cout, sum} !== golden(32'hDEAD_BEEF, 32'h2152_4111, 1'b1))
            $display("FAIL reset_fresh_op: got %h expected %h", {cout, sum}, golden(32'hDEAD_BEEF, 32'h2152_4111, 1'b1));
        else n_pass++;
    endtask

    task automatic test_random();
        logic [W-1:0] x, y;
        logic         c;
        logic [W:0]   e;
        int           cyc, bcyc, gap;
        for (int i = 0; i < 1000; i++) begin
            x = $urandom(); y = $urandom(); c = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: x = '1;
                1: y = '0;
                default: ;
            endcase
            exp_q.push_back(golden(x, y, c));
            do_op(x, y, c, 1'b0, cyc, bcyc);
            e = exp_q.pop_front();
            n_checks++;
            if ({cout, sum} !== e || cyc !== 4)
                $display("FAIL random_op %0d: got %h after %0d cycles expected %h after 4", i, {cout, sum}, cyc, e);
            else n_pass++;
            gap = $urandom_range(0, 3);
            repeat (gap) tick();
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_carry_ripple();
        test_cin_only();
        test_back_to_back();
        test_start_during_run();
        test_reset_mid_run();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
